computer_player: RTL and testbench

Computer opponent for the tug-of-war game. Drives the right-player press input of the playfield light chain with single-cycle press pulses. Timing is pseudo-random: a free-running LFSR is compared against a speed value from the switches. Sits between the switch/reset logic and the playfield lights, in place of the right-hand human key path.

---
 rtl/tug_pkg.sv | 19 +
 rtl/computer_player_lfsr.sv | 32 +++
 rtl/computer_player.sv | 111 +++++++++++
 tb/tb_computer_player.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game: computer-player FSM states and
// the LFSR width, tap positions and seed.
package tug_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        COOL  = 2'd3
    } cpu_state_e;

    localparam int LFSR_WIDTH  = 10;
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    // All-zero seed: with XNOR feedback the all-ones word is the lockup state.
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = '0;

endpackage

// File: rtl/computer_player_lfsr.sv
// Free-running Fibonacci LFSR (shift-left, XNOR feedback) with asynchronous
// reset to the package seed; advances every clock and exposes its full word.
module lfsr
    import tug_pkg::*;
#(
    parameter int W      = LFSR_WIDTH,
    parameter int TAP_HI = LFSR_TAP_HI,
    parameter int TAP_LO = LFSR_TAP_LO
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[W-2:0], ~(lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO])};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= W'(LFSR_SEED);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/computer_player.sv
// Computer opponent: emits single-cycle press pulses when the LFSR falls below
// speed. Define CPU_HOLDOFF_EN to add a HOLDOFF-cycle silent start after reset/nextRound.
module computer_player
    import tug_pkg::*;
#(
    parameter int LFSR_W   = LFSR_WIDTH,
    parameter int COOLDOWN = 4,
    parameter int HOLDOFF  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nextRound,
    input  logic              enable,
    input  logic [LFSR_W-1:0] speed,
    output logic              press
);

`ifdef CPU_HOLDOFF_EN
    localparam int         CNT_MAX     = (COOLDOWN > HOLDOFF) ? COOLDOWN : HOLDOFF;
    localparam cpu_state_e START_STATE = HOLD;
`else
    localparam int         CNT_MAX     = COOLDOWN;
    localparam cpu_state_e START_STATE = ARMED;
`endif
    localparam int              CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);
`ifdef CPU_HOLDOFF_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
`endif

    if (COOLDOWN < 1 || HOLDOFF < 1) begin : g_bad_params
        $error("computer_player: COOLDOWN and HOLDOFF must both be at least 1");
    end

    cpu_state_e       state_q;
    cpu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [LFSR_W-1:0] lfsr_value;
    logic             fire;

    lfsr #(
        .W      (LFSR_W),
        .TAP_HI (LFSR_TAP_HI),
        .TAP_LO (LFSR_TAP_LO)
    ) u_lfsr (
        .clk_i   (clk),
        .rst_i   (reset),
        .value_o (lfsr_value)
    );

    // speed is only looked at while ARMED; no copy of it is held.
    assign fire = (lfsr_value < speed);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= START_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (nextRound) begin
            state_d = START_STATE;
        end else begin
            case (state_q)
                HOLD: begin
`ifdef CPU_HOLDOFF_EN
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ARMED;
                    end
`else
                    state_d = ARMED;
`endif
                end
                ARMED: begin
                    if (enable && fire) begin
                        state_d = FIRE;
                    end
                end
                FIRE: begin
                    state_d = enable ? COOL : ARMED;
                end
                COOL: begin
                    if (!enable || cnt_q == COOL_LAST) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = START_STATE;
                end
            endcase
        end

        // Counter restarts on every entry to HOLD/COOL and saturates while staying there.
        cnt_d = '0;
        if (!nextRound && state_d == state_q && (state_q == HOLD || state_q == COOL)) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        press = (state_q == FIRE);
    end

endmodule

// File: tb/tb_computer_player.sv
// Self-checking bench for computer_player: a cycle model pushes expected
// press/LFSR values per edge, directed phases cover the timing corner cases.
module tb_computer_player;

    localparam int W  = 10;
    localparam int CD = 4;
    localparam int HO = 8;
`ifdef CPU_HOLDOFF_EN
    localparam int START_QUIET = HO;
`else
    localparam int START_QUIET = 0;
`endif

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         nextRound = 1'b0;
    logic         enable    = 1'b0;
    logic [W-1:0] speed     = '0;
    logic         press;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    computer_player #(
        .LFSR_W   (W),
        .COOLDOWN (CD),
        .HOLDOFF  (HO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .nextRound (nextRound),
        .enable    (enable),
        .speed     (speed),
        .press     (press)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: quiet = cycles left before the player is armed again.
    typedef struct packed {
        logic         press;
        logic [W-1:0] lfsr;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] m_lfsr  = '0;
    logic         m_fire  = 1'b0;
    logic         m_hold  = 1'b1;
    int           m_quiet = START_QUIET;

    task automatic model_reset();
        m_lfsr  = '0;
        m_fire  = 1'b0;
        m_hold  = 1'b1;
        m_quiet = START_QUIET;
        sb_q.delete();
    endtask

    task automatic model_step();
        logic fire_nxt;
        fire_nxt = 1'b0;
        if (nextRound) begin
            m_quiet = START_QUIET;
            m_hold  = 1'b1;
        end else if (m_fire) begin
            m_quiet = enable ? CD : 0;
            m_hold  = 1'b0;
        end else if (m_quiet > 0) begin
            if (!m_hold && !enable) m_quiet = 0;
            else m_quiet = m_quiet - 1;
        end else begin
            fire_nxt = enable && (m_lfsr < speed);
        end
        m_fire = fire_nxt;
        m_lfsr = {m_lfsr[W-2:0], ~(m_lfsr[9] ^ m_lfsr[6])};
        sb_q.push_back(exp_t'({m_fire, m_lfsr}));
    endtask

    task automatic check_front();
        exp_t e;
        e = sb_q.pop_front();
        check_val("press", {31'd0, press}, {31'd0, e.press});
        check_val("lfsr", {22'd0, dut.lfsr_value}, {22'd0, e.lfsr});
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(posedge clk) begin
        #1;
        if (!reset && sb_q.size() != 0) check_front();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic wait_press();
        for (int k = 0; k < 60 && !press; k++) step();
        if (!press) check_val("wait_press_timeout", {31'd0, press}, 32'd1);
    endtask

    initial begin
        int n;
        int first;
        int second;
        logic [W-1:0] seq [0:8];
        seq = '{10'd0, 10'd1, 10'd3, 10'd7, 10'd15, 10'd31, 10'd63, 10'd127, 10'd254};

        repeat (2) step();
        check_val("rst_press", {31'd0, press}, 32'd0);
        check_val("rst_lfsr", {22'd0, dut.lfsr_value}, 32'd0);

        // speed = 0 never fires
        speed  = '0;
        enable = 1'b1;
        reset  = 1'b0;
        n = 0;
        repeat (2000) begin
            step();
            if (press) n++;
        end
        check_val("speed0_presses", n, 0);
        $display("phase speed0: presses=%0d", n);

        // max speed: first press latency, spacing, LFSR sequence
        speed = '1;
        do_reset();
        first  = -1;
        second = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k <= 8) check_val("lfsr_seq", {22'd0, dut.lfsr_value}, {22'd0, seq[k]});
            if (press) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check_val("first_press_cycle", first, START_QUIET + 1);
        check_val("press_spacing", second - first, CD + 2);
        $display("phase maxspeed: first=%0d second=%0d", first, second);

        // mid-game nextRound
        wait_press();
        step();
        step();
        nextRound = 1'b1;
        step();
        nextRound = 1'b0;
        check_val("nr_next_press", {31'd0, press}, 32'd0);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (press) begin
                n = k;
                break;
            end
        end
        check_val("nr_first_press", n, START_QUIET + 1);
        $display("phase nextround: first press after %0d cycles", n);

        // nextRound on the same edge as the fire condition in ARMED
        repeat (CD + 1) step();
        nextRound = 1'b1;
        step();
        nextRound = 1'b0;
        check_val("nr_vs_fire", {31'd0, press}, 32'd0);
        $display("phase nr_vs_fire: press=%0d", press);

        // enable low during COOL
        wait_press();
        step();
        enable = 1'b0;
        repeat (3) begin
            step();
            check_val("en_low_press", {31'd0, press}, 32'd0);
        end
        enable = 1'b1;
        step();
        check_val("rearm_press", {31'd0, press}, 32'd1);
        $display("phase enable_low: rearm press=%0d", press);

        // asynchronous reset while press is high
        wait_press();
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_press", {31'd0, press}, 32'd0);
        check_val("async_rst_lfsr", {22'd0, dut.lfsr_value}, 32'd0);
        step();
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_val("lfsr_restart", {22'd0, dut.lfsr_value}, {22'd0, seq[k]});
        end
        $display("phase async_reset: lfsr=%0d", dut.lfsr_value);

        // randomised speed/enable/nextRound against the model
        for (int k = 0; k < 600; k++) begin
            speed     = W'($urandom_range(0, 1023));
            enable    = ($urandom_range(0, 9) != 0);
            nextRound = ($urandom_range(0, 39) == 0);
            step();
        end
        nextRound = 1'b0;
        step();
        $display("phase random: done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
